// File: rtl/pipe_pkg.sv
// pipe_pkg: MEM-stage state encoding and default bus-error fill value
package pipe_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: counts unacknowledged BUSY cycles, flags the last allowed one
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT) + 1;
    logic [W-1:0] cnt;
    assign expire = cnt == W'(TIMEOUT - 1);
    // clear while idle, advance on each BUSY cycle without ack
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM stage, drives the data-memory req/ack bus and stalls the pipe
module pipe_mem_stage
    import pipe_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mmo,
    output logic        wwreg,
    output logic [4:0]  wrn,
    output logic        mstall,
    output logic        maddr_err,
    output logic        mbus_err
);
    mem_state_t state;
    logic mem_op, access, misal, busy, expire;
    assign mem_op    = mm2reg | mwmem;
    assign access    = mem_op & (malu[1:0] == 2'b00);
    assign misal     = mem_op & (malu[1:0] != 2'b00);
    assign busy      = state == BUSY;
    assign mstall    = (state == IDLE & access) | busy;
    // mbus_err is only high in DONE, and mem_we still describes that access
    assign wwreg     = mwreg & ~mstall & ~misal & ~(mbus_err & ~mem_we);
    assign maddr_err = misal;
    assign wrn       = mrn;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clock  (clock),
        .resetn (resetn),
        .clr    (state == IDLE),
        .en     (busy & ~mem_ack & ~expire),
        .expire (expire)
    );

    // access sequencer: latch bus in IDLE, wait for ack or timeout in BUSY, release in DONE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mmo       <= '0;
            mbus_err  <= 1'b0;
        end else begin
            mbus_err <= 1'b0;
            case (state)
                IDLE: if (access) begin
                    mem_addr  <= malu;
                    mem_we    <= mwmem;
                    mem_wdata <= mb;
                    mem_req   <= 1'b1;
                    state     <= BUSY;
                end
                BUSY: if (mem_ack) begin
                    mem_req <= 1'b0;
                    if (!mem_we) mmo <= mem_rdata;
                    state   <= DONE;
                end else if (expire) begin
                    mem_req  <= 1'b0;
                    mbus_err <= 1'b1;
                    if (!mem_we) mmo <= ERR_DATA;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
- Consumes the registered control bits, ALU result, store data and destination register from EX/MEM.
- Drives a word-wide data-memory bus with a req/ack handshake.
- Stalls the upstream pipeline until the access completes, and presents load data plus a write-enable to the MEM/WB register.

Parameters:
- TIMEOUT, 16: max cycles in BUSY waiting for mem_ack before a bus error; minimum 2.
- ERR_DATA, 32'hDEADBEEF: value loaded into mmo on a bus timeout.

Ports:
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous active-low reset
- mwreg  in  1  register-write control from EX/MEM
- mm2reg  in  1  load (memory-to-register) from EX/MEM
- mwmem  in  1  store from EX/MEM
- malu  in  32  effective address / ALU result from EX/MEM
- mb  in  32  store data from EX/MEM
- mrn  in  5  destination register from EX/MEM
- mem_ack  in  1  data memory: access complete, rdata valid this cycle
- mem_rdata  in  32  data memory read data
- mem_req  out  1  data memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  32  word address, registered
- mem_wdata  out  32  write data, registered
- mmo  out  32  load result to MEM/WB, registered, held between loads
- wwreg  out  1  register-write enable to MEM/WB (gated)
- wrn  out  5  pass-through of mrn
- mstall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- maddr_err  out  1  misaligned-access pulse
- mbus_err  out  1  bus-timeout pulse, registered

Behaviour:
- Reset (async, resetn=0): state=IDLE; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mmo=0; mbus_err=0; timeout counter=0.
- Reset mid-access drops mem_req immediately; the pending access is abandoned.
- Definitions: access = (mm2reg|mwmem) & (malu[1:0]==2'b00); misal = (mm2reg|mwmem) & (malu[1:0]!=2'b00).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access: latch mem_addr=malu, mem_we=mwmem, mem_wdata=mb; set mem_req=1; clear counter; go BUSY. mstall=1 this cycle.
  - Else: stay in IDLE, mstall=0.
  - mem_ack in IDLE is ignored.
- BUSY:
  - mstall=1; mem_req stays 1 and the bus outputs stay stable.
  - On mem_ack: mem_req=0; mmo=mem_rdata if mem_we=0, otherwise mmo unchanged; go DONE.
  - If no ack and counter==TIMEOUT-1: mem_req=0; mbus_err=1 for one cycle; mmo=ERR_DATA if load; go DONE.
  - Otherwise the counter increments.
- DONE:
  - mstall=0, so the pipeline advances at the end of this cycle; unconditionally go IDLE.
  - The next instruction in EX/MEM is evaluated in the following IDLE cycle.
- Timing: a zero-wait memory (ack in the first BUSY cycle) gives 3 cycles per memory instruction (IDLE, BUSY, DONE). Each extra wait cycle adds 1. Non-memory instructions take 1 cycle with no stall.
- mstall is combinational: (state==IDLE & access) | (state==BUSY).
- wwreg = mwreg & ~mstall & ~misal & ~(load that ended in timeout). MEM/WB therefore captures a bubble during every stall cycle.
- maddr_err = misal, combinational. A misaligned access issues no request and no stall; a misaligned store performs no write.
- wrn = mrn, combinational.
- All arithmetic is unsigned; the counter is $clog2(TIMEOUT)+1 bits wide.

Decomposition:
- Shared package pipe_pkg: the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the ERR_DATA default.
- One natural sub-module: mem_timeout_cnt (clear, enable, expire output). Everything else stays in the top level.

Test Plan:
- Load, zero-wait: mm2reg=1, mwreg=1, malu=32'h40, memory acks in the first BUSY cycle with rdata=32'h1234_5678.
  -> mem_req high for 1 cycle with addr=32'h40, we=0; mstall high for 2 cycles; in DONE, mmo=32'h12345678 and wwreg=1.
- Store, 3 wait states: mwmem=1, malu=32'h100, mb=32'hCAFE_0001.
  -> mem_req, mem_we, addr and wdata stay stable for 4 cycles; mstall high for 5 cycles; wwreg=0; mmo unchanged.
- Misaligned load: malu=32'h41, mm2reg=1, mwreg=1.
  -> maddr_err=1, mem_req=0, mstall=0, wwreg=0.
- Timeout with TIMEOUT=4, no ack on a load.
  -> after 4 BUSY cycles: mbus_err pulses for one cycle, mmo=32'hDEADBEEF, wwreg=0 in DONE, FSM back to IDLE.
- Reset mid-access: assert resetn=0 during BUSY.
  -> mem_req drops to 0 immediately and all outputs return to reset values. After release, an ALU op (mwreg=1, no memory access) gives wwreg=1 and mstall=0.
- Back-to-back load then store, both zero-wait.
  -> two distinct bus transactions, no overlap of mem_req; the store's address and data are latched in the IDLE cycle that follows the load's DONE.
